mult24_scheduler: RTL and testbench

Round-robin scheduler that shares one pipelined 24x24 mantissa multiplier (the 2-stage unit returning product bits [47:23]) between N requesters. It sits between the FPU mantissa paths and the multiplier instance. It accepts at most one operand pair per cycle, registers it onto the multiplier inputs and tracks ownership through a tag pipeline matched to the multiplier latency. It delivers each 25-bit result with a one-hot owner strobe.

---
 rtl/mult24_scheduler.sv | 116 +++++++++++
 tb/tb_mult24_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mult24_scheduler.sv
// mult24_scheduler
//
// Round-robin front end that shares one pipelined 24x24 mantissa multiplier
// (result = product[47:23], LAT clocks from MA/MB to MR) between N
// requesters. One operand pair is accepted per cycle. The pair is registered
// onto MA/MB, and a {valid, id} tag travels alongside it so that the result
// can be returned with a one-hot owner strobe.
//
// Parameters
//   N     number of requesters (2..8)
//   LAT   multiplier latency, MA/MB inputs to MR output
//
// Ports
//   CLK    in   1      system clock, rising edge
//   RESET  in   1      asynchronous, active-high reset
//   REQ    in   N      request level per requester
//   A, B   in   N*24   operand pairs, slice i = [24*i+23:24*i]
//   ACK    out  N      one-hot grant, combinational
//   MA, MB out  24     registered operands to the multiplier
//   MR     in   25     multiplier result
//   R      out  25     registered result
//   RVLD   out  N      one-hot owner strobe for R, one cycle wide
//   BUSY   out  1      an issued operation has not yet produced RVLD
module mult24_scheduler #(
  parameter int N   = 4,
  parameter int LAT = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N-1:0]    REQ,
  input  logic [N*24-1:0] A,
  input  logic [N*24-1:0] B,
  output logic [N-1:0]    ACK,
  output logic [23:0]     MA,
  output logic [23:0]     MB,
  input  logic [24:0]     MR,
  output logic [24:0]     R,
  output logic [N-1:0]    RVLD,
  output logic            BUSY
);

  localparam int IW = $clog2(N);
  typedef logic [IW-1:0] id_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  id_t          ptr;
  logic         grant;
  id_t          gidx;

  // Stage 0 is aligned with MA/MB; stage LAT is aligned with MR.
  logic [LAT:0] tag_vld;
  logic [LAT:0] tag_vld_nxt;
  id_t          tag_id [LAT+1];
  logic         busy_nxt;

  // Round-robin search starting one past the last granted requester.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    for (int k = 1; k <= N; k++) begin
      if (!grant && REQ[(int'(ptr) + k) % N]) begin
        grant = 1'b1;
        gidx  = id_t'((int'(ptr) + k) % N);
      end
    end
    // No grant can be taken while reset holds the state cleared.
    if (RESET) grant = 1'b0;
  end

  assign ACK = grant ? (ONE << gidx) : '0;

  assign tag_vld_nxt = {tag_vld[LAT-1:0], grant};
  // The RVLD stage is busy next cycle exactly when the last tag is valid now.
  assign busy_nxt    = (|tag_vld_nxt) | tag_vld[LAT];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr     <= id_t'(N - 1);
      MA      <= '0;
      MB      <= '0;
      R       <= '0;
      RVLD    <= '0;
      BUSY    <= 1'b0;
      tag_vld <= '0;
    end else begin
      tag_vld <= tag_vld_nxt;
      BUSY    <= busy_nxt;
      if (grant) begin
        ptr <= gidx;
        MA  <= A[int'(gidx)*24 +: 24];
        MB  <= B[int'(gidx)*24 +: 24];
      end
      if (tag_vld[LAT]) begin
        R    <= MR;
        RVLD <= ONE << tag_id[LAT];
      end else begin
        RVLD <= '0;
      end
    end
  end

  // NOTE: the tag ids are payload qualified by tag_vld, so they carry no
  // reset; clearing the valids is enough to discard in-flight work.
  always_ff @(posedge CLK) begin
    tag_id[0] <= gidx;
    for (int s = 1; s <= LAT; s++) begin
      tag_id[s] <= tag_id[s-1];
    end
  end

endmodule

// File: tb/tb_mult24_scheduler.sv
// Testbench for mult24_scheduler (N=4, LAT=2). A two-register multiplier
// model drives MR. The reference keeps a round-robin pointer and a queue of
// expected results, each due LAT+2 cycles after its ACK cycle.
module tb_mult24_scheduler;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [N-1:0]    REQ;
  logic [N*24-1:0] A;
  logic [N*24-1:0] B;
  logic [N-1:0]    ACK;
  logic [23:0]     MA;
  logic [23:0]     MB;
  logic [24:0]     MR = '0;
  logic [24:0]     R;
  logic [N-1:0]    RVLD;
  logic            BUSY;
  logic [47:0]     mp1 = '0;

  mult24_scheduler #(.N(N), .LAT(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .A(A), .B(B), .ACK(ACK),
    .MA(MA), .MB(MB), .MR(MR), .R(R), .RVLD(RVLD), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Two-stage multiplier returning product[47:23].
  always @(posedge CLK) begin
    mp1 <= MA * MB;
    MR  <= mp1[47:23];
  end

  typedef struct {
    int          due;
    int          id;
    logic [24:0] r;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          mptr     = N - 1;
  logic [24:0] exp_r    = '0;
  logic [23:0] exp_ma   = '0;
  logic [23:0] exp_mb   = '0;
  logic [N-1:0] ack_s   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [24:0] prod(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] p;
    p = 48'(a) * 48'(b);
    return p[47:23];
  endfunction

  // Reference checker, sampled on the falling edge.
  logic [N-1:0] exp_ack;
  bit           retired;
  int           gsel;
  exp_t         e;

  always @(negedge CLK) begin
    if (RESET) begin
      check("rst_ack",  64'(ACK),  64'(0));
      check("rst_rvld", 64'(RVLD), 64'(0));
      check("rst_busy", 64'(BUSY), 64'(0));
      check("rst_r",    64'(R),    64'(0));
      check("rst_ma",   64'(MA),   64'(0));
      q.delete();
      mptr   = N - 1;
      exp_r  = '0;
      exp_ma = '0;
      exp_mb = '0;
      ack_s  = '0;
    end else begin
      retired = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("rvld", 64'(RVLD), 64'(1 << e.id));
        check("r",    64'(R),    64'(e.r));
        exp_r   = e.r;
        retired = 1'b1;
      end else begin
        check("rvld_idle", 64'(RVLD), 64'(0));
        check("r_hold",    64'(R),    64'(exp_r));
      end
      check("busy", 64'(BUSY), 64'(q.size() > 0 || retired));
      check("ma",   64'(MA),   64'(exp_ma));
      check("mb",   64'(MB),   64'(exp_mb));

      exp_ack = '0;
      gsel    = -1;
      for (int k = 1; k <= N; k++) begin
        if (gsel < 0 && REQ[(mptr + k) % N]) gsel = (mptr + k) % N;
      end
      if (gsel >= 0) exp_ack[gsel] = 1'b1;
      check("ack", 64'(ACK), 64'(exp_ack));
      if (gsel >= 0) begin
        mptr   = gsel;
        exp_ma = A[24*gsel +: 24];
        exp_mb = B[24*gsel +: 24];
        e.due  = cyc + LAT + 2;
        e.id   = gsel;
        e.r    = prod(exp_ma, exp_mb);
        q.push_back(e);
      end
      ack_s = ACK;
    end
    cyc++;
  end

  // One cycle of stimulus: requesters that are still waiting for ACK hold;
  // all others follow mask with a fresh (or fixed) operand pair.
  task automatic drive(input logic [N-1:0] mask, input bit fixed,
                       input logic [23:0] fa, input logic [23:0] fb);
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!(REQ[i] && !ack_s[i])) begin
        REQ[i]        = mask[i];
        A[24*i +: 24] = fixed ? fa : 24'($urandom);
        B[24*i +: 24] = fixed ? fb : 24'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, '0, '0);
  endtask

  // One-cycle reset pulse asserted mid-cycle, checked immediately.
  task automatic pulse_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    REQ   = '0;
    #1;
    check("rst_now_ma",   64'(MA),   64'(0));
    check("rst_now_mb",   64'(MB),   64'(0));
    check("rst_now_r",    64'(R),    64'(0));
    check("rst_now_busy", 64'(BUSY), 64'(0));
    check("rst_now_rvld", 64'(RVLD), 64'(0));
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    REQ   = '0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Single request, 1.0 x 1.0.
    drive(4'b0001, 1'b1, 24'h800000, 24'h800000);
    idle(6);

    // Round-robin with all requesters asserted.
    for (int i = 0; i < 8; i++) drive(4'b1111, 1'b0, '0, '0);
    idle(8);

    // Pointer wrap and skip: grant 2, then only 0 and 1 request.
    drive(4'b0100, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) drive(4'b0011, 1'b0, '0, '0);
    idle(8);

    // Back-to-back then a bubble.
    drive(4'b0001, 1'b0, '0, '0);
    drive(4'b0001, 1'b0, '0, '0);
    drive(4'b0000, 1'b0, '0, '0);
    drive(4'b0001, 1'b0, '0, '0);
    idle(6);

    // Maximum operands.
    drive(4'b0010, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
    idle(6);

    // Reset with two operations in flight.
    drive(4'b0011, 1'b0, '0, '0);
    drive(4'b0011, 1'b0, '0, '0);
    pulse_reset();
    drive(4'b1000, 1'b0, '0, '0);
    idle(8);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        pulse_reset();
        drive(4'b1111, 1'b0, '0, '0);
      end else if ($urandom_range(0, 15) == 0) begin
        drive(N'($urandom), 1'b1, 24'hFFFFFF, 24'($urandom));
      end else begin
        drive(N'($urandom), 1'b0, '0, '0);
      end
    end
    idle(10);

    check("drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
